// File: rtl/riscv_pkg.sv
// riscv_pkg: shared opcode/funct codes, ALU control encoding, pipeline
// register layouts and the ALU evaluation helper for the 5-stage core.
package riscv_pkg;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I_ALU  = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   localparam logic [2:0] F3_ADD_SUB = 3'b000;
   localparam logic [2:0] F3_SLL     = 3'b001;
   localparam logic [2:0] F3_SLT     = 3'b010;
   localparam logic [2:0] F3_XOR     = 3'b100;
   localparam logic [2:0] F3_SRL_SRA = 3'b101;
   localparam logic [2:0] F3_OR      = 3'b110;
   localparam logic [2:0] F3_AND     = 3'b111;
   localparam logic [2:0] F3_LW      = 3'b010;
   localparam logic [2:0] F3_SW      = 3'b010;
   localparam logic [2:0] F3_BEQ     = 3'b000;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   localparam logic [31:0] NOP_INSTRUCTION = 32'h0000_0013;

   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
      ALU_SLT, ALU_SLL, ALU_SRL, ALU_SRA
   } alu_ctrl_e;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] rs1_val;
      logic [31:0] rs2_val;
      logic [31:0] imm;
      logic [4:0]  rd;
      alu_ctrl_e   alu_op;
      logic        alu_src;
      logic        reg_write;
      logic        mem_read;
      logic        mem_write;
      logic        mem_to_reg;
      logic        branch;
   } id_ex_t;

   typedef struct packed {
      logic [31:0] alu;
      logic [31:0] wdata;
      logic [31:0] br_target;
      logic        zero;
      logic [4:0]  rd;
      logic        reg_write;
      logic        mem_read;
      logic        mem_write;
      logic        mem_to_reg;
      logic        branch;
   } ex_mem_t;

   typedef struct packed {
      logic [31:0] alu;
      logic [4:0]  rd;
      logic        reg_write;
      logic        mem_to_reg;
   } mem_wb_t;

   // Shift amounts use only the low 5 bits; slt compares signed.
   function automatic logic [31:0] alu_eval(alu_ctrl_e op, logic [31:0] a, logic [31:0] b);
      logic [31:0] r;
      case (op)
         ALU_ADD: r = a + b;
         ALU_SUB: r = a - b;
         ALU_AND: r = a & b;
         ALU_OR:  r = a | b;
         ALU_XOR: r = a ^ b;
         ALU_SLT: r = {31'b0, ($signed(a) < $signed(b))};
         ALU_SLL: r = a << b[4:0];
         ALU_SRL: r = a >> b[4:0];
         ALU_SRA: r = $signed(a) >>> b[4:0];
         default: r = '0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/riscv_regfile.sv
// riscv_regfile: 32x32 register file, two async read ports, one write port.
// Reads of the register being written this cycle return the write data, so
// a WB->ID distance of 3 needs no NOP. x0 always reads zero.
module riscv_regfile
   import riscv_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  rs1_addr,
   input  logic [4:0]  rs2_addr,
   output logic [31:0] rs1_data,
   output logic [31:0] rs2_data,
   input  logic        wr_en,
   input  logic [4:0]  wr_addr,
   input  logic [31:0] wr_data
);

   logic [31:0] regs [0:31];
   logic        wr_live;

   assign wr_live = wr_en && (wr_addr != 5'd0);

   // Write port; x0 is never written so it stays zero.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 32; i++) regs[i] <= '0;
      end else if (wr_live) begin
         regs[wr_addr] <= wr_data;
      end
   end

   // Read ports with write-through bypass.
   always_comb begin
      rs1_data = regs[rs1_addr];
      rs2_data = regs[rs2_addr];
      if (wr_live && wr_addr == rs1_addr) rs1_data = wr_data;
      if (wr_live && wr_addr == rs2_addr) rs2_data = wr_data;
      if (rs1_addr == 5'd0) rs1_data = '0;
      if (rs2_addr == 5'd0) rs2_data = '0;
   end

endmodule

// File: rtl/riscv_basic_pipeline_core.sv
// riscv_basic_pipeline_core: 5-stage in-order RV32I subset pipeline with no
// hazard detection and no forwarding. The synchronous imem output acts as the
// IF/ID instruction register. Optional build macro RISCV_BRANCH_FLUSH_EN:
// a taken beq squashes the three younger instructions; without it they run
// as delay slots.
module riscv_basic_pipeline_core
   import riscv_pkg::*;
#(
   parameter logic [31:0] INITIAL_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] instruction,
   output logic [31:0] PC,
   output logic [31:0] ALUResult,
   output logic [31:0] dAddress,
   output logic [31:0] dWriteData,
   input  logic [31:0] dReadData,
   output logic        MemRead,
   output logic        MemWrite,
   output logic [31:0] WriteBackData
);

   logic [31:0] pc_id;
   logic        kill_id;   // ID sees a NOP: out of reset, or squashed by a branch
   logic [31:0] inst;
   logic [31:0] rd1, rd2;
   logic [31:0] imm_i, imm_s, imm_b, alu_b;
   logic        br_taken;
   id_ex_t      id_ex, id_ex_d;
   ex_mem_t     ex_mem, ex_mem_d;
   mem_wb_t     mem_wb, mem_wb_d;

   assign inst  = kill_id ? NOP_INSTRUCTION : instruction;
   assign imm_i = {{20{inst[31]}}, inst[31:20]};
   assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
   assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};

   riscv_regfile u_regfile (
      .clk      (clk),
      .rst      (rst),
      .rs1_addr (inst[19:15]),
      .rs2_addr (inst[24:20]),
      .rs1_data (rd1),
      .rs2_data (rd2),
      .wr_en    (mem_wb.reg_write),
      .wr_addr  (mem_wb.rd),
      .wr_data  (WriteBackData)
   );

   // ID: decode; anything outside the supported subset leaves all control 0.
   always_comb begin
      id_ex_d         = '0;
      id_ex_d.pc      = pc_id;
      id_ex_d.rs1_val = rd1;
      id_ex_d.rs2_val = rd2;
      id_ex_d.rd      = inst[11:7];
      id_ex_d.alu_op  = ALU_ADD;
      case (inst[6:0])
         OP_R: begin
            if (inst[31:25] == F7_BASE ||
                (inst[31:25] == F7_ALT && (inst[14:12] == F3_ADD_SUB || inst[14:12] == F3_SRL_SRA))) begin
               id_ex_d.reg_write = 1'b1;
               case (inst[14:12])
                  F3_ADD_SUB: id_ex_d.alu_op = inst[30] ? ALU_SUB : ALU_ADD;
                  F3_SLL:     id_ex_d.alu_op = ALU_SLL;
                  F3_SLT:     id_ex_d.alu_op = ALU_SLT;
                  F3_XOR:     id_ex_d.alu_op = ALU_XOR;
                  F3_SRL_SRA: id_ex_d.alu_op = inst[30] ? ALU_SRA : ALU_SRL;
                  F3_OR:      id_ex_d.alu_op = ALU_OR;
                  default:    id_ex_d.alu_op = ALU_AND;
               endcase
            end
         end
         OP_I_ALU: begin
            id_ex_d.alu_src = 1'b1;
            id_ex_d.imm     = imm_i;
            case (inst[14:12])
               F3_ADD_SUB: id_ex_d.reg_write = 1'b1;
               F3_SLT: begin id_ex_d.reg_write = 1'b1; id_ex_d.alu_op = ALU_SLT; end
               F3_XOR: begin id_ex_d.reg_write = 1'b1; id_ex_d.alu_op = ALU_XOR; end
               F3_OR:  begin id_ex_d.reg_write = 1'b1; id_ex_d.alu_op = ALU_OR;  end
               F3_AND: begin id_ex_d.reg_write = 1'b1; id_ex_d.alu_op = ALU_AND; end
               default: ;
            endcase
         end
         OP_LOAD: begin
            if (inst[14:12] == F3_LW) begin
               id_ex_d.alu_src    = 1'b1;
               id_ex_d.imm        = imm_i;
               id_ex_d.reg_write  = 1'b1;
               id_ex_d.mem_read   = 1'b1;
               id_ex_d.mem_to_reg = 1'b1;
            end
         end
         OP_STORE: begin
            if (inst[14:12] == F3_SW) begin
               id_ex_d.alu_src   = 1'b1;
               id_ex_d.imm       = imm_s;
               id_ex_d.mem_write = 1'b1;
            end
         end
         OP_BRANCH: begin
            if (inst[14:12] == F3_BEQ) begin
               id_ex_d.imm    = imm_b;
               id_ex_d.alu_op = ALU_SUB;
               id_ex_d.branch = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // EX: ALU, branch target and zero flag for beq.
   always_comb begin
      alu_b                = id_ex.alu_src ? id_ex.imm : id_ex.rs2_val;
      ALUResult            = alu_eval(id_ex.alu_op, id_ex.rs1_val, alu_b);
      ex_mem_d.alu         = ALUResult;
      ex_mem_d.wdata       = id_ex.rs2_val;
      ex_mem_d.br_target   = id_ex.pc + id_ex.imm;
      ex_mem_d.zero        = (ALUResult == 32'd0);
      ex_mem_d.rd          = id_ex.rd;
      ex_mem_d.reg_write   = id_ex.reg_write;
      ex_mem_d.mem_read    = id_ex.mem_read;
      ex_mem_d.mem_write   = id_ex.mem_write;
      ex_mem_d.mem_to_reg  = id_ex.mem_to_reg;
      ex_mem_d.branch      = id_ex.branch;
   end

   // MEM: drive the data bus and resolve beq.
   assign dAddress   = ex_mem.alu;
   assign dWriteData = ex_mem.wdata;
   assign MemRead    = ex_mem.mem_read;
   assign MemWrite   = ex_mem.mem_write;
   assign br_taken   = ex_mem.branch & ex_mem.zero;

   // MEM->WB register contents.
   always_comb begin
      mem_wb_d.alu        = ex_mem.alu;
      mem_wb_d.rd         = ex_mem.rd;
      mem_wb_d.reg_write  = ex_mem.reg_write;
      mem_wb_d.mem_to_reg = ex_mem.mem_to_reg;
   end

   // WB: load data arrives from the sync dmem during this stage.
   assign WriteBackData = mem_wb.mem_to_reg ? dReadData : mem_wb.alu;

   // PC and pipeline registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         PC      <= INITIAL_PC;
         pc_id   <= '0;
         kill_id <= 1'b1;
         id_ex   <= '0;
         ex_mem  <= '0;
         mem_wb  <= '0;
      end else begin
         PC     <= br_taken ? ex_mem.br_target : PC + 32'd4;
         pc_id  <= PC;
         mem_wb <= mem_wb_d;
`ifdef RISCV_BRANCH_FLUSH_EN
         kill_id <= br_taken;
         id_ex   <= br_taken ? '0 : id_ex_d;
         ex_mem  <= br_taken ? '0 : ex_mem_d;
`else
         kill_id <= 1'b0;
         id_ex   <= id_ex_d;
         ex_mem  <= ex_mem_d;
`endif
      end
   end

endmodule

// File: tb/tb_riscv_basic_pipeline_core.sv
// Self-checking bench: random hazard-free programs (every register producer
// at least 3 fetch slots ahead of its consumers) are executed by an
// instruction-level model; per-stage outputs are predicted from fixed stage
// latencies of each fetched instruction.
module tb_riscv_basic_pipeline_core;

   localparam int NCYC = 200;
   localparam int IMW  = 512;
`ifdef RISCV_BRANCH_FLUSH_EN
   localparam bit FLUSH = 1'b1;
`else
   localparam bit FLUSH = 1'b0;
`endif

   typedef enum int {I_ADD, I_SUB, I_AND, I_OR, I_XOR, I_SLT, I_SLL, I_SRL, I_SRA,
                     I_ADDI, I_ANDI, I_ORI, I_XORI, I_SLTI, I_LW, I_SW, I_BEQ} op_t;
   typedef struct {
      op_t op;
      int  rd;
      int  rs1;
      int  rs2;
      int  imm;
   } ins_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] instruction, dReadData;
   logic [31:0] PC, ALUResult, dAddress, dWriteData, WriteBackData;
   logic        MemRead, MemWrite;

   logic [31:0] imem  [IMW];
   logic [31:0] dinit [64];
   logic [31:0] dmem  [64];
   ins_t        prog  [IMW];
   int          wp;

   logic [31:0] e_pc [NCYC], e_alu [NCYC], e_addr [NCYC], e_wd [NCYC], e_wb [NCYC];
   bit          e_alu_chk [NCYC], e_addr_chk [NCYC], e_wb_chk [NCYC], e_mr [NCYC], e_mw [NCYC];

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   always #5 clk = ~clk;

   riscv_basic_pipeline_core #(.INITIAL_PC(32'h0)) dut (
      .clk           (clk),
      .rst           (rst),
      .instruction   (instruction),
      .PC            (PC),
      .ALUResult     (ALUResult),
      .dAddress      (dAddress),
      .dWriteData    (dWriteData),
      .dReadData     (dReadData),
      .MemRead       (MemRead),
      .MemWrite      (MemWrite),
      .WriteBackData (WriteBackData)
   );

   // Synchronous instruction and data memories (1-cycle latency).
   always @(posedge clk) begin
      instruction <= imem[PC[10:2]];
      if (!rst) begin
         for (int i = 0; i < 64; i++) dmem[i] <= dinit[i];
         dReadData <= '0;
      end else begin
         dReadData <= dmem[dAddress[7:2]];
         if (MemWrite) dmem[dAddress[7:2]] <= dWriteData;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
      end
   endtask

   function automatic ins_t mk(op_t op, int rd, int rs1, int rs2, int imm);
      ins_t i;
      i.op = op; i.rd = rd; i.rs1 = rs1; i.rs2 = rs2; i.imm = imm;
      return i;
   endfunction

   function automatic logic [31:0] enc(ins_t i);
      logic [31:0] im = i.imm;
      logic [4:0]  d  = 5'(i.rd);
      logic [4:0]  s1 = 5'(i.rs1);
      logic [4:0]  s2 = 5'(i.rs2);
      logic [2:0]  f3;
      logic [6:0]  f7;
      f7 = (i.op == I_SUB || i.op == I_SRA) ? 7'h20 : 7'h00;
      case (i.op)
         I_SLL:                 f3 = 3'd1;
         I_SLT, I_SLTI, I_LW, I_SW: f3 = 3'd2;
         I_XOR, I_XORI:         f3 = 3'd4;
         I_SRL, I_SRA:          f3 = 3'd5;
         I_OR, I_ORI:           f3 = 3'd6;
         I_AND, I_ANDI:         f3 = 3'd7;
         default:               f3 = 3'd0;
      endcase
      case (i.op)
         I_ADD, I_SUB, I_AND, I_OR, I_XOR, I_SLT, I_SLL, I_SRL, I_SRA:
            return {f7, s2, s1, f3, d, 7'h33};
         I_LW:  return {im[11:0], s1, f3, d, 7'h03};
         I_SW:  return {im[11:5], s2, s1, f3, im[4:0], 7'h23};
         I_BEQ: return {im[12], im[10:5], s2, s1, 3'b000, im[4:1], im[11], 7'h63};
         default: return {im[11:0], s1, f3, d, 7'h13};
      endcase
   endfunction

   function automatic int simm();
      return int'($urandom_range(0, 4095)) - 2048;
   endfunction

   function automatic ins_t rand_ins();
      int   rds [5] = '{0, 1, 2, 4, 5};
      op_t  op  = op_t'($urandom_range(0, 15));
      int   rd  = rds[$urandom_range(0, 4)];
      int   r1  = int'($urandom_range(0, 7));
      int   r2  = int'($urandom_range(0, 7));
      if (op == I_LW || op == I_SW) return mk(op, rd, 3, r2, 4 * int'($urandom_range(0, 15)));
      return mk(op, rd, r1, r2, simm());
   endfunction

   task automatic put(input ins_t i);
      prog[wp] = i;
      wp++;
   endtask

   task automatic put_grp(input ins_t i);
      put(i);
      put(mk(I_ADDI, 0, 0, 0, 0));
      put(mk(I_ADDI, 0, 0, 0, 0));
   endtask

   task automatic gen_prog();
      int r1, r2;
      for (int i = 0; i < IMW; i++) prog[i] = mk(I_ADDI, 0, 0, 0, 0);
      wp = 0;
      put_grp(mk(I_ADDI, 1, 0, 0, simm()));
      put_grp(mk(I_ADDI, 2, 0, 0, simm()));
      put_grp(mk(I_ADDI, 4, 0, 0, simm()));
      put_grp(mk(I_ADDI, 5, 0, 0, simm()));
      put_grp(mk(I_ADDI, 3, 0, 0, 'h400));
      put_grp(mk(I_ADDI, 6, 0, 0, 31));
      put_grp(mk(I_ADDI, 7, 0, 0, 1));
      put_grp(mk(I_SLL, 7, 7, 6, 0));          // x7 = 0x80000000
      for (int g = 0; g < 40; g++) begin
         if ($urandom_range(0, 5) == 0) begin
            r1 = int'($urandom_range(0, 7));
            r2 = ($urandom_range(0, 1) == 1) ? r1 : int'($urandom_range(0, 7));
            put(mk(I_BEQ, 0, r1, r2, 16 + 12 * int'($urandom_range(0, 2))));
            put(rand_ins());
            put(mk(I_ADDI, 0, 0, 0, 0));
            put(mk(I_ADDI, 0, 0, 0, 0));
         end else begin
            put_grp(rand_ins());
         end
      end
      for (int i = 0; i < IMW; i++) imem[i] = enc(prog[i]);
      for (int i = 0; i < 64; i++) dinit[i] = $urandom;
   endtask

   // Instruction-level execution of the fetch stream; beq redirects the
   // fetch 4 slots later, the 3 slots in between are delay slots (or squashed).
   task automatic run_model();
      logic [31:0] r [32];
      logic [31:0] md [64];
      bit          tk [NCYC];
      logic [31:0] tg [NCYC];
      logic [31:0] pc, a, b, res, ld;
      ins_t        in;
      bit          kill1, kill23, wr;
      for (int i = 0; i < 32; i++) r[i] = '0;
      for (int i = 0; i < 64; i++) md[i] = dinit[i];
      pc = '0;
      for (int k = 0; k < NCYC; k++) begin
         if (k == 0) pc = '0;
         else if (k >= 4 && tk[k-4]) pc = tg[k-4];
         else pc = pc + 32'd4;
         e_pc[k] = pc;
         in = ((pc >> 2) < IMW) ? prog[pc >> 2] : mk(I_ADDI, 0, 0, 0, 0);
         kill1  = FLUSH && k >= 1 && tk[k-1];
         kill23 = FLUSH && ((k >= 2 && tk[k-2]) || (k >= 3 && tk[k-3]));
         if (kill23) in = mk(I_ADDI, 0, 0, 0, 0);
         a = r[in.rs1];
         b = (in.op <= I_SRA || in.op == I_SW || in.op == I_BEQ) ? r[in.rs2] : in.imm;
         tk[k] = 0; tg[k] = '0; wr = 1; ld = '0;
         e_alu_chk[k] = 1; e_addr_chk[k] = 1; e_wb_chk[k] = 1;
         e_mr[k] = 0; e_mw[k] = 0; e_wd[k] = '0;
         case (in.op)
            I_ADD, I_ADDI: res = a + b;
            I_SUB:         res = a - b;
            I_AND, I_ANDI: res = a & b;
            I_OR, I_ORI:   res = a | b;
            I_XOR, I_XORI: res = a ^ b;
            I_SLT, I_SLTI: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            I_SLL:         res = a << b[4:0];
            I_SRL:         res = a >> b[4:0];
            I_SRA:         res = $signed(a) >>> b[4:0];
            I_LW: begin res = a + in.imm; ld = md[res[7:2]]; e_mr[k] = 1; end
            I_SW: begin res = a + in.imm; wr = 0; e_mw[k] = 1; e_wd[k] = b; end
            default: begin // beq
               res = '0; wr = 0;
               tk[k] = (a == b); tg[k] = pc + in.imm;
               e_alu_chk[k] = 0; e_addr_chk[k] = 0; e_wb_chk[k] = 0;
            end
         endcase
         e_alu[k]  = res;
         e_addr[k] = res;
         e_wb[k]   = (in.op == I_LW) ? ld : res;
         if (kill1) begin
            e_addr[k] = '0; e_wb[k] = '0; e_mr[k] = 0; e_mw[k] = 0;
            e_addr_chk[k] = 1; e_wb_chk[k] = 1; tk[k] = 0;
         end else begin
            if (wr && in.rd != 0) r[in.rd] = e_wb[k];
            if (in.op == I_SW) md[res[7:2]] = b;
         end
      end
   endtask

   initial begin
      int j;
      for (int it = 0; it < 3; it++) begin
         gen_prog();
         run_model();
         @(negedge clk);
         rst = 1'b0;
         #1;
         cyc = -1;
         chk("rst_pc", PC, 32'h0);
         chk("rst_mrd", 32'(MemRead), 32'h0);
         chk("rst_mwr", 32'(MemWrite), 32'h0);
         repeat (3) @(posedge clk);
         @(negedge clk);
         chk("rst_pc_hold", PC, 32'h0);
         chk("rst_alu", ALUResult, 32'h0);
         chk("rst_wb", WriteBackData, 32'h0);
         chk("rst_addr", dAddress, 32'h0);
         rst = 1'b1;
         for (int c = 0; c < NCYC; c++) begin
            cyc = c;
            chk("pc", PC, e_pc[c]);
            j = c - 2;
            if (j < 0) chk("alu", ALUResult, 32'h0);
            else if (e_alu_chk[j]) chk("alu", ALUResult, e_alu[j]);
            j = c - 3;
            if (j < 0) begin
               chk("addr", dAddress, 32'h0);
               chk("mrd", 32'(MemRead), 32'h0);
               chk("mwr", 32'(MemWrite), 32'h0);
            end else begin
               if (e_addr_chk[j]) chk("addr", dAddress, e_addr[j]);
               chk("mrd", 32'(MemRead), 32'(e_mr[j]));
               chk("mwr", 32'(MemWrite), 32'(e_mw[j]));
               if (e_mw[j]) chk("wdata", dWriteData, e_wd[j]);
            end
            j = c - 4;
            if (j < 0) chk("wb", WriteBackData, 32'h0);
            else if (e_wb_chk[j]) chk("wb", WriteBackData, e_wb[j]);
            @(posedge clk);
            @(negedge clk);
         end
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
